// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, sequencer states and icode classifiers.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] IIADDQ  = 4'hC;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPDATE,
    S_HALT
  } state_t;

  function automatic logic is_mem_icode(input logic [3:0] icode);
    return icode inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
  endfunction

  function automatic logic is_write_icode(input logic [3:0] icode);
    return icode inside {IRMMOVQ, ICALL, IPUSHQ};
  endfunction

  function automatic logic is_valid_icode(input logic [3:0] icode);
    return icode <= IIADDQ;
  endfunction

endpackage

// File: rtl/seq_stage_sequencer_mem_wait_timer.sv
// Memory wait timer shared by FETCH and MEMORY; sat flags the waiting cycle that
// would bring the count to all-ones, so an ack arriving in that same cycle still wins.
module mem_wait_timer #(
  parameter int W = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic sat
);

  localparam logic [W-1:0] LAST = W'((2 ** W) - 2);

  logic [W-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clear) begin
      timer_d = '0;
    end else if (count && (timer_q != '1)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign sat = count && (timer_q == LAST);

endmodule

// File: rtl/seq_stage_sequencer.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ datapath: one stage strobe per cycle,
// memory handshakes with a shared timeout, status and retired-instruction count.
module seq_stage_sequencer
  import y86_pkg::*;
#(
  parameter int TIMEOUT_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       icode_in,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic             imem_error,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  input  logic             dmem_error,
  output logic             decode_en,
  output logic             exec_en,
  output logic             cc_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q, state_d;
  logic [3:0]       icode_q, icode_d;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             waiting, mem_ack, tmr_sat;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEMORY);
  assign mem_ack = (state_q == S_FETCH) ? imem_ack : dmem_ack;

  mem_wait_timer #(.W(TIMEOUT_W)) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (!waiting),
    .count (waiting && !mem_ack),
    .sat   (tmr_sat)
  );

  always_comb begin
    state_d       = state_q;
    icode_d       = icode_q;
    stat_d        = stat_q;
    instr_count_d = instr_count_q;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    decode_en     = 1'b0;
    exec_en       = 1'b0;
    cc_en         = 1'b0;
    wb_en         = 1'b0;
    pc_en         = 1'b0;
    busy          = !((state_q == S_IDLE) || (state_q == S_HALT));
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (imem_error) begin
            stat_d  = SADR;
            state_d = S_HALT;
          end else begin
            icode_d = icode_in;
            if (!is_valid_icode(icode_in)) begin
              stat_d  = SINS;
              state_d = S_HALT;
            end else if (icode_in == IHALT) begin
              stat_d  = SHLT;
              state_d = S_HALT;
            end else begin
              state_d = S_DECODE;
            end
          end
        end else if (tmr_sat) begin
          stat_d  = SADR;
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        decode_en = 1'b1;
        state_d   = S_EXECUTE;
      end
      S_EXECUTE: begin
        exec_en = 1'b1;
        cc_en   = (icode_q == IOPQ);
        state_d = is_mem_icode(icode_q) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = is_write_icode(icode_q);
        if (dmem_ack) begin
          if (dmem_error) begin
            stat_d  = SADR;
            state_d = S_HALT;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (tmr_sat) begin
          stat_d  = SADR;
          state_d = S_HALT;
        end
      end
      S_WRITEBACK: begin
        wb_en   = 1'b1;
        state_d = S_PCUPDATE;
      end
      S_PCUPDATE: begin
        pc_en         = 1'b1;
        instr_count_d = instr_count_q + 1'b1;
        state_d       = S_FETCH;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      icode_q       <= IHALT;
      stat_q        <= SAOK;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      icode_q       <= icode_d;
      stat_q        <= stat_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign stat        = stat_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_seq_stage_sequencer.sv
// Bench for seq_stage_sequencer: instruction programs are expanded into an expected
// per-cycle output trace and compared against two instances (TIMEOUT_W=4 and TIMEOUT_W=2).
module tb_seq_stage_sequencer;

  // strobe vector bit order: imem_req dmem_req dmem_we decode exec cc wb pc busy
  localparam logic [8:0] V_IMEM = 9'b100000001;
  localparam logic [8:0] V_DMEM = 9'b010000001;
  localparam logic [8:0] V_WE   = 9'b001000000;
  localparam logic [8:0] V_DEC  = 9'b000100001;
  localparam logic [8:0] V_EXE  = 9'b000010001;
  localparam logic [8:0] V_CC   = 9'b000001000;
  localparam logic [8:0] V_WB   = 9'b000000101;
  localparam logic [8:0] V_PC   = 9'b000000011;

  typedef struct packed {
    logic [8:0]  s;
    logic [2:0]  st;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    int icode;
    int wf;
    int ferr;
    int wm;
    int merr;
  } txn_t;

  logic       clock = 1'b0;
  logic       reset, start, imem_ack, imem_error, dmem_ack, dmem_error;
  logic [3:0] icode_in;
  vec_t       obs [2];
  txn_t       txq [$];
  vec_t       exp_q [$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         prog_id = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        imem_req, dmem_req, dmem_we, decode_en, exec_en, cc_en, wb_en, pc_en, busy;
    logic [2:0]  stat;
    logic [31:0] instr_count;
    seq_stage_sequencer #(.TIMEOUT_W(g == 0 ? 4 : 2), .CNT_W(32)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .icode_in    (icode_in),
      .imem_req    (imem_req),
      .imem_ack    (imem_ack),
      .imem_error  (imem_error),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_ack    (dmem_ack),
      .dmem_error  (dmem_error),
      .decode_en   (decode_en),
      .exec_en     (exec_en),
      .cc_en       (cc_en),
      .wb_en       (wb_en),
      .pc_en       (pc_en),
      .stat        (stat),
      .busy        (busy),
      .instr_count (instr_count)
    );
    assign obs[g] = {imem_req, dmem_req, dmem_we, decode_en, exec_en, cc_en, wb_en, pc_en, busy,
                     stat, instr_count};
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // dmem_we only carries meaning while a data request is expected
  task automatic cmp_vec(input string tag, input vec_t o, input vec_t e);
    logic [8:0] sg;
    sg    = o.s;
    sg[6] = o.s[6] & e.s[7];
    check_eq({tag, " strobes"}, 64'(sg), 64'(e.s));
    check_eq({tag, " stat"}, 64'(o.st), 64'(e.st));
    check_eq({tag, " count"}, 64'(o.cnt), 64'(e.cnt));
  endtask

  function automatic vec_t mk(input logic [8:0] s, input logic [2:0] st, input int cnt);
    vec_t v;
    v.s   = s;
    v.st  = st;
    v.cnt = 32'(cnt);
    return v;
  endfunction

  task automatic add_txn(input int icode, input int wf, input int ferr, input int wm, input int merr);
    txn_t t;
    t.icode = icode; t.wf = wf; t.ferr = ferr; t.wm = wm; t.merr = merr;
    txq.push_back(t);
  endtask

  // lim = cycles a request may stay unanswered before the access faults
  task automatic build(input int lim);
    int   cnt;
    int   n;
    txn_t t;
    cnt = 0;
    exp_q.delete();
    foreach (txq[i]) begin
      t = txq[i];
      n = (t.wf < lim) ? t.wf + 1 : lim;
      repeat (n) exp_q.push_back(mk(V_IMEM, 3'd1, cnt));
      if (t.wf >= lim || t.ferr != 0) begin
        repeat (3) exp_q.push_back(mk(9'b0, 3'd3, cnt));
        return;
      end
      if (t.icode >= 13) begin
        repeat (3) exp_q.push_back(mk(9'b0, 3'd4, cnt));
        return;
      end
      if (t.icode == 0) begin
        repeat (3) exp_q.push_back(mk(9'b0, 3'd2, cnt));
        return;
      end
      exp_q.push_back(mk(V_DEC, 3'd1, cnt));
      exp_q.push_back(mk((t.icode == 6) ? (V_EXE | V_CC) : V_EXE, 3'd1, cnt));
      if (t.icode inside {4, 5, 8, 9, 10, 11}) begin
        n = (t.wm < lim) ? t.wm + 1 : lim;
        repeat (n) exp_q.push_back(mk(V_DMEM | ((t.icode inside {4, 8, 10}) ? V_WE : 9'b0), 3'd1, cnt));
        if (t.wm >= lim || t.merr != 0) begin
          repeat (3) exp_q.push_back(mk(9'b0, 3'd3, cnt));
          return;
        end
      end
      exp_q.push_back(mk(V_WB, 3'd1, cnt));
      exp_q.push_back(mk(V_PC, 3'd1, cnt));
      cnt++;
    end
  endtask

  task automatic run_prog(input int sel, input int abort_at);
    int   fcnt, dcnt, di;
    vec_t o;
    txn_t t;
    fcnt = 0; dcnt = 0; di = 0;
    prog_id++;
    build((sel == 0) ? 15 : 3);
    reset = 1'b1; start = 1'b0; icode_in = 4'h0;
    imem_ack = 1'b0; imem_error = 1'b0; dmem_ack = 1'b0; dmem_error = 1'b0;
    repeat (2) @(negedge clock);
    cmp_vec($sformatf("p%0d reset", prog_id), obs[sel], mk(9'b0, 3'd1, 0));
    reset = 1'b0; start = 1'b1;
    @(negedge clock);
    foreach (exp_q[k]) begin
      o = obs[sel];
      cmp_vec($sformatf("p%0d c%0d", prog_id, k), o, exp_q[k]);
      if (k == abort_at) begin
        reset = 1'b1; start = 1'b0;
        @(negedge clock);
        cmp_vec($sformatf("p%0d abort", prog_id), obs[sel], mk(9'b0, 3'd1, 0));
        reset = 1'b0;
        @(negedge clock);
        cmp_vec($sformatf("p%0d post_abort", prog_id), obs[sel], mk(9'b0, 3'd1, 0));
        return;
      end
      if (di < txq.size()) t = txq[di];
      start      = ($urandom_range(0, 7) == 0);
      icode_in   = 4'($urandom);
      imem_error = 1'($urandom);
      dmem_error = 1'($urandom);
      imem_ack   = 1'b0;
      dmem_ack   = 1'b0;
      if (o.s[8]) begin
        if (fcnt == t.wf) begin
          imem_ack = 1'b1; imem_error = (t.ferr != 0); icode_in = 4'(t.icode); fcnt = 0;
        end else begin
          fcnt++;
        end
      end else begin
        imem_ack = ($urandom_range(0, 3) == 0);
      end
      if (o.s[7]) begin
        if (dcnt == t.wm) begin
          dmem_ack = 1'b1; dmem_error = (t.merr != 0); dcnt = 0;
        end else begin
          dcnt++;
        end
      end else begin
        dmem_ack = ($urandom_range(0, 3) == 0);
      end
      if (o.s[1]) di++;
      @(negedge clock);
    end
  endtask

  initial begin
    // OPQ with zero-wait fetch, then HALT
    txq.delete(); add_txn(6, 0, 0, 0, 0); add_txn(0, 0, 0, 0, 0);
    run_prog(0, -1);
    // MRMOVQ with three data wait cycles
    txq.delete(); add_txn(5, 0, 0, 3, 0); add_txn(0, 0, 0, 0, 0);
    run_prog(0, -1);
    // PUSHQ writes, then HALT leaves count at 1
    txq.delete(); add_txn(10, 1, 0, 0, 0); add_txn(0, 2, 0, 0, 0);
    run_prog(0, -1);
    // illegal icode E
    txq.delete(); add_txn(14, 0, 0, 0, 0);
    run_prog(0, -1);
    // RMMOVQ data fault
    txq.delete(); add_txn(4, 0, 0, 1, 1); add_txn(0, 0, 0, 0, 0);
    run_prog(0, -1);
    // TIMEOUT_W=2: fetch never answered
    txq.delete(); add_txn(1, 100, 0, 0, 0);
    run_prog(1, -1);
    // TIMEOUT_W=2: ack lands on the saturating cycle
    txq.delete(); add_txn(6, 2, 0, 0, 0); add_txn(0, 0, 0, 0, 0);
    run_prog(1, -1);
    // reset while waiting in MEMORY after one retired instruction
    txq.delete(); add_txn(6, 0, 0, 0, 0); add_txn(5, 0, 0, 5, 0); add_txn(0, 0, 0, 0, 0);
    run_prog(0, 10);

    for (int p = 0; p < 30; p++) begin
      int sel, n, ab;
      sel = $urandom_range(0, 1);
      n   = $urandom_range(2, 6);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
      txq.delete();
      for (int i = 0; i < n; i++) begin
        add_txn(($urandom_range(0, 19) < 16) ? $urandom_range(1, 12) : $urandom_range(0, 15),
                $urandom_range(0, 4), ($urandom_range(0, 15) == 0) ? 1 : 0,
                $urandom_range(0, 4), ($urandom_range(0, 15) == 0) ? 1 : 0);
      end
      add_txn(0, 0, 0, 0, 0);
      run_prog(sel, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
